// File: rtl/int_source.sv
// int_source: programmable external-interrupt source for the CPU's
// m_int_addr/m_int_byteen acknowledge interface. Supports one-shot delay,
// periodic and (optionally) PC-match triggering, with sticky overrun flag
// and a wrapping acknowledge counter.
// Optional feature macro: INT_SOURCE_PCMATCH_EN builds the MATCH state and
// PC comparator; without it mode 11 behaves as mode 00.
module int_source #(
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [31:0]      cfg_pc,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    output logic             interrupt,
    output logic             overrun,
    output logic [7:0]       ack_count
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_MATCH, S_ASSERT} state_t;

    localparam logic [1:0] MODE_OFF      = 2'b00;
    localparam logic [1:0] MODE_ONESHOT  = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;
    localparam logic [1:0] MODE_PCMATCH  = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             interrupt_q, interrupt_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       ack_count_q, ack_count_d;

    logic             ack;
    logic             expired;
    logic [CNT_W-1:0] cnt_step;

`ifdef INT_SOURCE_PCMATCH_EN
    logic [31:0] pc_q, pc_d;
    logic        unused_bits;
    assign unused_bits = ^m_int_addr[1:0];
`else
    logic        unused_bits;
    assign unused_bits = ^{m_int_addr[1:0], cfg_pc, macroscopic_pc};
`endif

    // Acknowledge decode (word address match with at least one byte lane)
    // and the shared counter step: decrement, reload to the period on expiry.
    assign ack      = (m_int_addr[31:2] == ACK_ADDR[31:2]) && (|m_int_byteen);
    assign expired  = (cnt_q == '0);
    assign cnt_step = expired ? period_q : cnt_q - 1'b1;

    // Next-state and output-register logic; cfg_we overrides everything.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        interrupt_d = interrupt_q;
        overrun_d   = overrun_q;
        ack_count_d = ack_count_q;
`ifdef INT_SOURCE_PCMATCH_EN
        pc_d        = pc_q;
`endif
        if (cfg_we) begin
            mode_d      = cfg_mode;
            period_d    = cfg_count;
            interrupt_d = 1'b0;
            overrun_d   = 1'b0;
`ifdef INT_SOURCE_PCMATCH_EN
            pc_d        = cfg_pc;
`endif
            case (cfg_mode)
                MODE_ONESHOT, MODE_PERIODIC: begin
                    state_d = S_COUNT;
                    cnt_d   = cfg_count;
                end
`ifdef INT_SOURCE_PCMATCH_EN
                MODE_PCMATCH: state_d = S_MATCH;
`endif
                default:      state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_COUNT: begin
                    cnt_d = cnt_step;
                    if (expired) begin
                        interrupt_d = 1'b1;
                        state_d     = S_ASSERT;
                    end
                end
`ifdef INT_SOURCE_PCMATCH_EN
                S_MATCH: begin
                    if (macroscopic_pc == pc_q) begin
                        interrupt_d = 1'b1;
                        state_d     = S_ASSERT;
                    end
                end
`endif
                S_ASSERT: begin
                    if (mode_q == MODE_PERIODIC) begin
                        // Period keeps running regardless of ack timing.
                        cnt_d = cnt_step;
                        if (ack) begin
                            ack_count_d = ack_count_q + 8'd1;
                            // An ack coinciding with expiry re-arms immediately.
                            if (!expired) begin
                                interrupt_d = 1'b0;
                                state_d     = S_COUNT;
                            end
                        end else if (expired) begin
                            overrun_d = 1'b1;
                        end
                    end else if (ack) begin
                        interrupt_d = 1'b0;
                        ack_count_d = ack_count_q + 8'd1;
                        state_d     = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_OFF;
            cnt_q       <= '0;
            period_q    <= '0;
            interrupt_q <= 1'b0;
            overrun_q   <= 1'b0;
            ack_count_q <= '0;
`ifdef INT_SOURCE_PCMATCH_EN
            pc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            interrupt_q <= interrupt_d;
            overrun_q   <= overrun_d;
            ack_count_q <= ack_count_d;
`ifdef INT_SOURCE_PCMATCH_EN
            pc_q        <= pc_d;
`endif
        end
    end

    assign interrupt = interrupt_q;
    assign overrun   = overrun_q;
    assign ack_count = ack_count_q;

endmodule

// File: tb/tb_int_source.sv
// Testbench for int_source: directed scenarios with constant expectations,
// then randomized traffic checked cycle by cycle against a time-stamp model.
module tb_int_source;
    localparam int CNT_W = 16;
    localparam logic [29:0] ACK_WORD = 30'h1FC8; // 0x7F20 >> 2
`ifdef INT_SOURCE_PCMATCH_EN
    localparam bit PCEN = 1'b1;
`else
    localparam bit PCEN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_mode = 2'b00;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [31:0]      cfg_pc = '0;
    logic [31:0]      macroscopic_pc = '0;
    logic [31:0]      m_int_addr = '0;
    logic [3:0]       m_int_byteen = '0;
    logic             interrupt;
    logic             overrun;
    logic [7:0]       ack_count;

    int tests_run = 0;
    int tests_failed = 0;

    int_source dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
        .cfg_count(cfg_count), .cfg_pc(cfg_pc), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .interrupt(interrupt), .overrun(overrun), .ack_count(ack_count)
    );

    always #5 clk = ~clk;

    // Reference model: tracks absolute edge numbers and the edge at which the
    // next expiry is due, instead of a down-counter.
    int         m_t = 0;
    int         m_next = 0;
    int         m_period = 0;
    bit         m_int = 0;
    bit         m_ovr = 0;
    bit         m_active = 0;
    bit         m_match = 0;
    logic [1:0] m_mode = 2'b00;
    logic [31:0] m_pc = '0;
    logic [7:0] m_acks = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_int = 0; m_ovr = 0; m_acks = '0; m_mode = 2'b00;
            m_active = 0; m_match = 0;
        end else begin
            bit hit;
            bit exp_now;
            m_t = m_t + 1;
            hit = m_int && (m_int_addr[31:2] == ACK_WORD) && (m_int_byteen != 4'd0);
            if (cfg_we) begin
                m_mode = (cfg_mode == 2'b11 && !PCEN) ? 2'b00 : cfg_mode;
                m_int = 0; m_ovr = 0;
                m_period = int'(cfg_count);
                m_next = m_t + m_period + 1;
                m_active = (m_mode == 2'b01) || (m_mode == 2'b10);
                m_match = (m_mode == 2'b11);
                m_pc = cfg_pc;
            end else begin
                case (m_mode)
                    2'b01: begin
                        if (m_int) begin
                            if (hit) begin m_int = 0; m_acks = m_acks + 8'd1; end
                        end else if (m_active && m_t == m_next) begin
                            m_int = 1; m_active = 0;
                        end
                    end
                    2'b10: begin
                        exp_now = (m_t == m_next);
                        if (exp_now) m_next = m_next + m_period + 1;
                        if (m_int) begin
                            if (hit) begin m_acks = m_acks + 8'd1; m_int = exp_now; end
                            else if (exp_now) m_ovr = 1;
                        end else if (exp_now) begin
                            m_int = 1;
                        end
                    end
                    2'b11: begin
                        if (m_int) begin
                            if (hit) begin m_int = 0; m_match = 0; m_acks = m_acks + 8'd1; end
                        end else if (m_match && macroscopic_pc == m_pc) begin
                            m_int = 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_idle();
        m_int_addr = '0;
        m_int_byteen = '0;
    endtask

    task automatic bus_ack(input logic [31:0] addr, input logic [3:0] be);
        m_int_addr = addr;
        m_int_byteen = be;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_we = 1'b0;
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives cfg_we for exactly one edge ("edge 0") and returns after it.
    task automatic apply_cfg(input logic [1:0] mode, input int cnt, input logic [31:0] pc);
        cfg_we = 1'b1;
        cfg_mode = mode;
        cfg_count = CNT_W'(cnt);
        cfg_pc = pc;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL reset_int got %b exp 0", interrupt); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        tests_run++; if (ack_count !== 8'd0) begin tests_failed++; $display("FAIL reset_acks got %0d exp 0", ack_count); end
        reset = 1'b0;
    endtask

    task automatic test_oneshot();
        int rises;
        do_reset();
        apply_cfg(2'b01, 5, 32'h0);
        for (int e = 1; e <= 9; e++) begin
            tick();
            tests_run++;
            if (interrupt !== (e >= 6)) begin
                tests_failed++; $display("FAIL oneshot_int edge %0d got %b exp %b", e, interrupt, (e >= 6));
            end
        end
        bus_ack(32'h0000_7F20, 4'b1111);
        tick();
        bus_idle();
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL oneshot_ack_int got %b exp 0", interrupt); end
        tests_run++; if (ack_count !== 8'd1) begin tests_failed++; $display("FAIL oneshot_ack_cnt got %0d exp 1", ack_count); end
        rises = 0;
        repeat (50) begin tick(); rises += int'(interrupt); end
        tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL oneshot_quiet got %0d high cycles exp 0", rises); end
    endtask

    task automatic test_ack_filter();
        do_reset();
        apply_cfg(2'b01, 0, 32'h0);
        tick();
        tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL filter_n0_rise got %b exp 1", interrupt); end
        bus_ack(32'h0000_7F20, 4'b0000);
        tick();
        tests_run++; if ({interrupt, ack_count} !== {1'b1, 8'd0}) begin tests_failed++; $display("FAIL filter_be0 got int %b acks %0d exp 1/0", interrupt, ack_count); end
        bus_ack(32'h0000_7F24, 4'b0001);
        tick();
        tests_run++; if ({interrupt, ack_count} !== {1'b1, 8'd0}) begin tests_failed++; $display("FAIL filter_addr got int %b acks %0d exp 1/0", interrupt, ack_count); end
        bus_ack(32'h0000_7F22, 4'b0100);
        tick();
        bus_idle();
        tests_run++; if ({interrupt, ack_count} !== {1'b0, 8'd1}) begin tests_failed++; $display("FAIL filter_lane2 got int %b acks %0d exp 0/1", interrupt, ack_count); end
    endtask

    task automatic test_periodic();
        bit   exp_int;
        bit   exp_ovr;
        int   exp_acks;
        do_reset();
        apply_cfg(2'b10, 3, 32'h0);
        for (int e = 1; e <= 20; e++) begin
            if (e == 6 || e == 10 || e == 14) bus_ack(32'h0000_7F20, 4'b1111);
            tick();
            bus_idle();
            exp_int  = (e >= 16) || (e >= 4 && (e % 4 == 0 || e % 4 == 1));
            exp_ovr  = (e >= 20);
            exp_acks = (e >= 14) ? 3 : (e >= 10) ? 2 : (e >= 6) ? 1 : 0;
            tests_run++;
            if ({interrupt, overrun, ack_count} !== {exp_int, exp_ovr, 8'(exp_acks)}) begin
                tests_failed++;
                $display("FAIL periodic edge %0d got int %b ovr %b acks %0d exp %b %b %0d",
                         e, interrupt, overrun, ack_count, exp_int, exp_ovr, exp_acks);
            end
        end
    endtask

    task automatic test_collisions();
        do_reset();
        apply_cfg(2'b10, 0, 32'h0);
        tick();
        tests_run++; if ({interrupt, overrun} !== 2'b10) begin tests_failed++; $display("FAIL coll_p0_rise got int %b ovr %b exp 1 0", interrupt, overrun); end
        tick();
        tests_run++; if ({interrupt, overrun} !== 2'b11) begin tests_failed++; $display("FAIL coll_p0_ovr got int %b ovr %b exp 1 1", interrupt, overrun); end
        cfg_we = 1'b1; cfg_mode = 2'b00;
        bus_ack(32'h0000_7F20, 4'b1111);
        tick();
        cfg_we = 1'b0; bus_idle();
        tests_run++; if ({interrupt, overrun, ack_count} !== {1'b0, 1'b0, 8'd0}) begin tests_failed++; $display("FAIL coll_cfg_ack got int %b ovr %b acks %0d exp 0 0 0", interrupt, overrun, ack_count); end

        do_reset();
        apply_cfg(2'b10, 2, 32'h0);
        repeat (5) tick();
        tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL coll_pre got %b exp 1", interrupt); end
        bus_ack(32'h0000_7F20, 4'b0010);
        tick();
        tests_run++; if ({interrupt, overrun, ack_count} !== {1'b1, 1'b0, 8'd1}) begin tests_failed++; $display("FAIL coll_ack_exp got int %b ovr %b acks %0d exp 1 0 1", interrupt, overrun, ack_count); end
        tick();
        bus_idle();
        tests_run++; if ({interrupt, ack_count} !== {1'b0, 8'd2}) begin tests_failed++; $display("FAIL coll_ack2 got int %b acks %0d exp 0 2", interrupt, ack_count); end
        tick();
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL coll_gap got %b exp 0", interrupt); end
        tick();
        tests_run++; if ({interrupt, overrun} !== 2'b10) begin tests_failed++; $display("FAIL coll_next got int %b ovr %b exp 1 0", interrupt, overrun); end
    endtask

    task automatic test_pcmatch();
        int  rises;
        bit  exp_int;
        do_reset();
        macroscopic_pc = 32'h0000_3010;
        apply_cfg(2'b11, 0, 32'h0000_3010);
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL pc_cfg_edge got %b exp 0", interrupt); end
        for (int i = 0; i <= 4; i++) begin
            macroscopic_pc = 32'h0000_3000 + 32'(4 * i);
            tick();
            exp_int = PCEN && (i == 4);
            tests_run++;
            if (interrupt !== exp_int) begin tests_failed++; $display("FAIL pc_walk step %0d got %b exp %b", i, interrupt, exp_int); end
        end
        macroscopic_pc = 32'h0000_3014;
        bus_ack(32'h0000_7F20, 4'b1111);
        tick();
        bus_idle();
        tests_run++;
        if ({interrupt, ack_count} !== {1'b0, 8'(PCEN)}) begin
            tests_failed++; $display("FAIL pc_ack got int %b acks %0d exp 0 %0d", interrupt, ack_count, PCEN);
        end
        macroscopic_pc = 32'h0000_3010;
        rises = 0;
        repeat (5) begin tick(); rises += int'(interrupt); end
        tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL pc_refire got %0d high cycles exp 0", rises); end
    endtask

    task automatic test_async_reset();
        int rises;
        do_reset();
        apply_cfg(2'b01, 0, 32'h0);
        tick();
        bus_ack(32'h0000_7F20, 4'b1000);
        tick();
        bus_idle();
        apply_cfg(2'b10, 10, 32'h0);
        repeat (3) tick();
        tests_run++; if (ack_count !== 8'd1) begin tests_failed++; $display("FAIL areset_pre got acks %0d exp 1", ack_count); end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({interrupt, overrun, ack_count} !== {1'b0, 1'b0, 8'd0}) begin
            tests_failed++; $display("FAIL areset_now got int %b ovr %b acks %0d exp 0 0 0", interrupt, overrun, ack_count);
        end
        @(negedge clk);
        reset = 1'b0;
        rises = 0;
        repeat (30) begin tick(); rises += int'(interrupt); end
        tests_run++; if (rises !== 0) begin tests_failed++; $display("FAIL areset_after got %0d high cycles exp 0", rises); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            tests_run++;
            if ({interrupt, overrun, ack_count} !== {m_int, m_ovr, m_acks}) begin
                tests_failed++;
                $display("FAIL random cycle %0d got int %b ovr %b acks %0d exp %b %b %0d",
                         c, interrupt, overrun, ack_count, m_int, m_ovr, m_acks);
            end
            reset  = ($urandom_range(0, 299) == 0);
            cfg_we = ($urandom_range(0, 29) == 0);
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_count = CNT_W'($urandom_range(0, 6));
            cfg_pc = 32'h0000_3000 + 32'(4 * $urandom_range(0, 3));
            macroscopic_pc = 32'h0000_3000 + 32'(4 * $urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1:    m_int_addr = 32'h0000_7F20 + 32'($urandom_range(0, 3));
                2:       m_int_addr = 32'h0000_7F24;
                default: m_int_addr = 32'h0000_0000;
            endcase
            m_int_byteen = 4'($urandom_range(0, 15));
        end
        reset = 1'b0;
        cfg_we = 1'b0;
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_ack_filter();
        test_periodic();
        test_collisions();
        test_pcmatch();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
